// File: rtl/imem_access_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// imem_access_ctrl
//
// Arbitrates a single-port instruction memory (1-cycle synchronous read)
// between the core fetch port and a program loader. It provides the fetch
// stall, loader burst locking, word-address decode and misalignment
// detection. It sits between the fetch stage and the memory array.
//
// Parameters
//   AW        word-address width (2**AW words, byte address bits [AW+1:2])
//   LOAD_PRIO 1: loader wins a simultaneous request in IDLE, 0: fetch wins
//   MAX_WAIT  fetch starvation limit in cycles (STARVE_GUARD_EN builds only)
//
// Build option
//   STARVE_GUARD_EN  defined: a fetch that has waited MAX_WAIT cycles is
//                    forced through in IDLE, even while the loader lock is
//                    held. Undefined: the loader lock is absolute.
//
// Ports
//   clk, rst                  clock (rising edge), async active-low reset
//   if_req/if_addr            fetch request (held until if_valid), byte PC
//   if_rdata/if_valid         fetched word, 1-cycle valid pulse
//   if_stall                  fetch pending and not yet returned
//   ld_req/ld_addr/ld_wdata   loader write request (held until ld_ack)
//   ld_last                   final word of a loader burst
//   ld_ack                    1-cycle pulse, word written
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   memory array interface
//   load_busy                 loader burst lock held
//   err_misal                 1-cycle pulse with the response of a
//                             misaligned access
// -----------------------------------------------------------------------------
module imem_access_ctrl #(
  parameter int AW        = 10,
  parameter int LOAD_PRIO = 1,
  parameter int MAX_WAIT  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic [31:0]   if_rdata,
  output logic          if_valid,
  output logic          if_stall,
  input  logic          ld_req,
  input  logic [31:0]   ld_addr,
  input  logic [31:0]   ld_wdata,
  input  logic          ld_last,
  output logic          ld_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          load_busy,
  output logic          err_misal
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_FETCH_RD = 2'd1;
  localparam logic [1:0] ST_LOAD_WR  = 2'd2;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;
  localparam logic        LD_WINS  = (LOAD_PRIO != 0);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        lock;
  logic        misal_q;   // access in flight was misaligned
  logic        last_q;    // ld_last captured at loader grant
  logic [31:0] rdata_q;   // last returned fetch word, held between pulses

  logic        if_misal;
  logic        ld_misal;
  logic        force_fetch;
  logic        fetch_gnt;
  logic        load_gnt;

  // Upper address bits are ignored on purpose: addresses wrap modulo
  // 2**(AW+2) bytes.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:AW+2], ld_addr[31:AW+2]};

  assign if_misal = |if_addr[1:0];
  assign ld_misal = |ld_addr[1:0];

`ifdef STARVE_GUARD_EN
  localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  logic [WW-1:0] wait_cnt;

  // Counts cycles a fetch has been waiting; saturates, clears on delivery.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (if_valid) begin
      wait_cnt <= '0;
    end else if (if_req && (wait_cnt != WW'(MAX_WAIT))) begin
      wait_cnt <= wait_cnt + WW'(1);
    end
  end

  assign force_fetch = (wait_cnt == WW'(MAX_WAIT));
`else
  localparam int unused_max_wait = MAX_WAIT;

  assign force_fetch = 1'b0;
`endif

  // Grants are only evaluated in IDLE and are blocked while reset is held so
  // that every output reads inactive during reset.
  assign fetch_gnt = rst && (state == ST_IDLE) && if_req &&
                     (force_fetch || (!lock && (!ld_req || !LD_WINS)));
  assign load_gnt  = rst && (state == ST_IDLE) && ld_req && !fetch_gnt &&
                     (lock || !if_req || LD_WINS);

  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if_valid  = 1'b0;
    ld_ack    = 1'b0;
    err_misal = 1'b0;
    if_rdata  = rdata_q;
    case (state)
      ST_IDLE: begin
        if (fetch_gnt) begin
          state_nxt = ST_FETCH_RD;
          if (!if_misal) begin
            mem_en   = 1'b1;
            mem_addr = if_addr[AW+1:2];
          end
        end else if (load_gnt) begin
          state_nxt = ST_LOAD_WR;
          if (!ld_misal) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = ld_addr[AW+1:2];
            mem_wdata = ld_wdata;
          end
        end
      end
      ST_FETCH_RD: begin
        state_nxt = ST_IDLE;
        if_valid  = 1'b1;
        err_misal = misal_q;
        // A misaligned fetch never touched memory; return a NOP instead.
        if_rdata  = misal_q ? NOP_INSN : mem_rdata;
      end
      ST_LOAD_WR: begin
        state_nxt = ST_IDLE;
        ld_ack    = 1'b1;
        err_misal = misal_q;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      lock    <= 1'b0;
      misal_q <= 1'b0;
      last_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (fetch_gnt) begin
        misal_q <= if_misal;
      end else if (load_gnt) begin
        misal_q <= ld_misal;
        last_q  <= ld_last;
      end
      if (state == ST_FETCH_RD) begin
        rdata_q <= if_rdata;
      end
      // Lock follows every loader response, including misaligned ones; a
      // forced fetch leaves it untouched.
      if (state == ST_LOAD_WR) begin
        lock <= !last_q;
      end
    end
  end

  assign if_stall  = if_req && !if_valid;
  assign load_busy = lock;

endmodule
